// File: rtl/data_ram_pkg.sv
// Shared types, constants and helpers for the MIPS SOPC data-memory responder.
package data_ram_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;
    localparam logic [SEL_W-1:0] SEL_HALF_HI = 4'b1100;
    localparam logic [SEL_W-1:0] SEL_HALF_LO = 4'b0011;
    localparam logic [SEL_W-1:0] SEL_B0      = 4'b1000;
    localparam logic [SEL_W-1:0] SEL_B1      = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_B2      = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_B3      = 4'b0001;

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // True when the byte-enable pattern is a supported size aligned to addr[1:0].
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (sel)
            SEL_WORD:    ok = (addr_lo == 2'b00);
            SEL_HALF_HI: ok = (addr_lo == 2'b00);
            SEL_HALF_LO: ok = (addr_lo == 2'b10);
            SEL_B0:      ok = (addr_lo == 2'b00);
            SEL_B1:      ok = (addr_lo == 2'b01);
            SEL_B2:      ok = (addr_lo == 2'b10);
            SEL_B3:      ok = (addr_lo == 2'b11);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Store data arrives right-justified; replicate it so every enabled lane sees it.
    function automatic logic [DATA_W-1:0] lane_data(input logic [SEL_W-1:0] sel,
                                                    input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] d;
        d = data;
        case (sel)
            SEL_HALF_HI, SEL_HALF_LO:        d = {2{data[15:0]}};
            SEL_B0, SEL_B1, SEL_B2, SEL_B3:  d = {4{data[7:0]}};
            default:                         d = data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Byte-enabled word storage: synchronous write, combinational read, no reset.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [SEL_W-1:0]      be,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(SEL_W); b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_ram_slave.sv
// MEM-stage data-memory slave: one request at a time, programmable wait states, ack/err pulse.
module data_ram_slave
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack_o,
    output logic              mem_err_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    mem_req_t          req, req_n;
    mem_req_t          cur_req_c, acc_c;
    logic              acc_err_c, done_c, wr_c;
    logic [DATA_W-1:0] rdata_c, data_n;
    logic              ack_n, err_n, busy_n;

    // With zero wait states the access completes on the accept edge, so use live inputs there.
    assign cur_req_c = '{we: mem_we_i, addr: mem_addr_i, sel: mem_sel_i, data: mem_data_i};
    assign acc_c     = (state == IDLE) ? cur_req_c : req;
    assign acc_err_c = !sel_legal(acc_c.sel, acc_c.addr[1:0])
                     || (acc_c.addr[31:ADDR_WIDTH+2] != '0);
    assign wr_c      = done_c && acc_c.we && !acc_err_c;

    data_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .we    (wr_c),
        .be    (acc_c.sel),
        .idx   (acc_c.addr[ADDR_WIDTH+1:2]),
        .wdata (lane_data(acc_c.sel, acc_c.data)),
        .rdata (rdata_c)
    );

    // Next state, wait counter and next registered outputs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = req;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_ce_i) begin
                    req_n = cur_req_c;
                    if (WAIT_CYCLES == 0) begin
                        state_n = ACK;
                        done_c  = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = ACK;
                    done_c  = 1'b1;
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ack_n  = done_c;
        err_n  = done_c && acc_err_c;
        data_n = (done_c && !acc_err_c && !acc_c.we) ? rdata_c : '0;
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req        <= '0;
            mem_data_o <= '0;
            mem_ack_o  <= 1'b0;
            mem_err_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req        <= req_n;
            mem_data_o <= data_n;
            mem_ack_o  <= ack_n;
            mem_err_o  <= err_n;
            busy_o     <= busy_n;
        end
    end

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: three instances (1, 0 and 3 wait states) against a timing/memory model.
module tb_data_ram_slave;

    localparam int unsigned AW = 10;
    localparam int NDUT = 3;

    logic        clk, rst;
    logic        ce    [NDUT];
    logic        we    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [3:0]  sel   [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];
    logic        busy  [NDUT];

    int checks, errors;

    data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_addr_i(addr[0]),
        .mem_sel_i(sel[0]), .mem_data_i(wdata[0]), .mem_data_o(rdata[0]),
        .mem_ack_o(ack[0]), .mem_err_o(err[0]), .busy_o(busy[0]));
    data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_addr_i(addr[1]),
        .mem_sel_i(sel[1]), .mem_data_i(wdata[1]), .mem_data_o(rdata[1]),
        .mem_ack_o(ack[1]), .mem_err_o(err[1]), .busy_o(busy[1]));
    data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we[2]), .mem_addr_i(addr[2]),
        .mem_sel_i(sel[2]), .mem_data_i(wdata[2]), .mem_data_o(rdata[2]),
        .mem_ack_o(ack[2]), .mem_err_o(err[2]), .busy_o(busy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int          ecnt;
    int          nxt_acc [NDUT];
    int          acc_e   [NDUT];
    int          ack_e   [NDUT];
    bit          pend    [NDUT];
    logic        cw      [NDUT];
    logic [31:0] ca      [NDUT];
    logic [31:0] cd      [NDUT];
    logic [3:0]  cs      [NDUT];
    logic        e_ack   [NDUT];
    logic        e_err   [NDUT];
    logic        e_busy  [NDUT];
    bit          e_dv    [NDUT];
    logic [31:0] e_data  [NDUT];
    logic [31:0] mdl_mem [int];

    function automatic bit legal_access(input logic [3:0] s, input logic [31:0] a);
        int n;
        int lo;
        n  = $countones(s);
        lo = int'(a[1:0]);
        if ((a >> (AW + 2)) != 32'd0) return 1'b0;
        if (n == 4) return lo == 0;
        if (n == 2) return (lo % 2 == 0) && (s == (4'b1100 >> lo));
        if (n == 1) return s == (4'b1000 >> lo);
        return 1'b0;
    endfunction

    task automatic execute(input int i);
        int          key, n, lo;
        logic [31:0] w;
        key = i * 4096 + int'(ca[i][AW+1:2]);
        e_ack[i] = 1'b1;
        if (!legal_access(cs[i], ca[i])) begin
            e_err[i] = 1'b1;
            return;
        end
        if (cw[i]) begin
            if (mdl_mem.exists(key) || cs[i] == 4'hF) begin
                n  = $countones(cs[i]);
                lo = int'(ca[i][1:0]);
                w  = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (cs[i][3-b]) w[8*(3-b) +: 8] = cd[i][8*(n-1-(b-lo)) +: 8];
                mdl_mem[key] = w;
            end
        end else if (mdl_mem.exists(key)) begin
            e_data[i] = mdl_mem[key];
        end else begin
            e_dv[i] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NDUT; i++) begin
                pend[i] = 1'b0; nxt_acc[i] = 0; acc_e[i] = -10; ack_e[i] = -10;
                e_ack[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0;
                e_data[i] = 32'h0; e_dv[i] = 1'b1;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < NDUT; i++) begin
                e_ack[i] = 1'b0; e_err[i] = 1'b0; e_data[i] = 32'h0; e_dv[i] = 1'b1;
                if (!pend[i] && ecnt >= nxt_acc[i] && ce[i]) begin
                    cw[i] = we[i]; ca[i] = addr[i]; cs[i] = sel[i]; cd[i] = wdata[i];
                    acc_e[i]   = ecnt;
                    ack_e[i]   = ecnt + wait_of(i);
                    nxt_acc[i] = ack_e[i] + 2;
                    pend[i]    = 1'b1;
                end
                if (pend[i] && ecnt == ack_e[i]) begin
                    execute(i);
                    pend[i] = 1'b0;
                end
                e_busy[i] = (ecnt >= acc_e[i]) && (ecnt <= ack_e[i]);
            end
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, i, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            check("ack", i, 32'(ack[i]), 32'(e_ack[i]));
            check("err", i, 32'(err[i]), 32'(e_err[i]));
            check("busy", i, 32'(busy[i]), 32'(e_busy[i]));
            if (e_dv[i]) check("data", i, rdata[i], e_data[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_access(input int i, input bit sync, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d, input int hold,
                             output logic [31:0] rd, output logic er, output int lat);
        bit seen;
        seen = 1'b0; rd = 32'h0; er = 1'b0; lat = 0;
        if (sync) begin @(posedge clk); #3; end
        ce[i] = 1'b1; we[i] = w; addr[i] = a; sel[i] = s; wdata[i] = d;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #3;
            if (c >= hold) ce[i] = 1'b0;
            else begin
                we[i] = 1'($urandom); addr[i] = $urandom; sel[i] = 4'($urandom); wdata[i] = $urandom;
            end
            @(negedge clk);
            if (ack[i]) begin
                seen = 1'b1; lat = c; rd = rdata[i]; er = err[i];
                break;
            end
        end
        if (ce[i]) begin @(posedge clk); #3; ce[i] = 1'b0; end
        check("ack_seen", i, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] pre_val(input int j);
        return (j == 1) ? 32'h0 : (32'hA5A5_0000 + 32'(j));
    endfunction

    initial begin
        logic [31:0] rd, a;
        logic        er;
        logic [3:0]  s;
        logic [5:0]  apat, bpat;
        int          lat, n, i, lo;

        rst = 1'b0; checks = 0; errors = 0; ecnt = 0;
        for (int k = 0; k < NDUT; k++) begin
            ce[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; sel[k] = 4'h0; wdata[k] = 32'h0;
        end
        repeat (100) @(posedge clk);
        #3;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ack", k, 32'(ack[k]), 32'd0);
            check("rst_busy", k, 32'(busy[k]), 32'd0);
            check("rst_data", k, rdata[k], 32'h0);
        end
        rst = 1'b1;

        // Preload; the very first request follows reset release directly.
        for (int k = 0; k < NDUT; k++) begin
            for (int j = 0; j < 8; j++) begin
                do_access(k, !(k == 0 && j == 0), 1'b1, 32'h40 + 32'(4*j), 4'hF, pre_val(j), 1, rd, er, lat);
                if (k == 0 && j == 0) check("first_latency", 0, 32'(lat), 32'd2);
            end
            do_access(k, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 1, rd, er, lat);
        end

        // Word store/load with one wait state.
        do_access(0, 1'b1, 1'b1, 32'h40, 4'b1111, 32'h1234_5678, 1, rd, er, lat);
        check("word_st_lat", 0, 32'(lat), 32'd2);
        check("word_st_err", 0, 32'(er), 32'd0);
        do_access(0, 1'b1, 1'b0, 32'h40, 4'b1111, 32'h0, 1, rd, er, lat);
        check("word_ld", 0, rd, 32'h1234_5678);

        // Big-endian byte store.
        do_access(0, 1'b1, 1'b1, 32'h46, 4'b0010, 32'h0000_00AB, 1, rd, er, lat);
        do_access(0, 1'b1, 1'b0, 32'h44, 4'b1111, 32'h0, 1, rd, er, lat);
        check("byte_ld", 0, rd, 32'h0000_AB00);

        // Illegal accesses leave memory untouched.
        do_access(0, 1'b1, 1'b1, 32'h48, 4'b0101, 32'hFFFF_FFFF, 1, rd, er, lat);
        check("bad_sel_err", 0, 32'(er), 32'd1);
        check("bad_sel_data", 0, rd, 32'h0);
        do_access(0, 1'b1, 1'b1, 32'h4A, 4'b1111, 32'hFFFF_FFFF, 1, rd, er, lat);
        check("misalign_err", 0, 32'(er), 32'd1);
        do_access(0, 1'b1, 1'b0, 32'h48, 4'b1111, 32'h0, 1, rd, er, lat);
        check("bad_reload", 0, rd, 32'hA5A5_0002);
        do_access(0, 1'b1, 1'b1, 32'h0000_1000, 4'b1111, 32'h1111_1111, 1, rd, er, lat);
        check("range_err", 0, 32'(er), 32'd1);
        do_access(0, 1'b1, 1'b0, 32'h0, 4'b1111, 32'h0, 1, rd, er, lat);
        check("range_reload", 0, rd, 32'h0BAD_F00D);

        // Back-to-back with zero wait states: ce held for six edges.
        @(posedge clk); #3;
        ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; sel[1] = 4'hF;
        apat = '0; bpat = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #3;
            if (c == 5) ce[1] = 1'b0;
            @(negedge clk);
            apat = {apat[4:0], ack[1]};
            bpat = {bpat[4:0], busy[1]};
        end
        check("b2b_ack_pattern", 1, 32'(apat), 32'(6'b101010));
        check("b2b_busy_pattern", 1, 32'(bpat), 32'(6'b101010));
        n = 0;
        repeat (3) begin @(negedge clk); if (ack[1]) n++; end
        check("b2b_no_extra", 1, 32'(n), 32'd0);

        // Reset during the wait phase abandons the store.
        @(posedge clk); #3;
        ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h50; sel[2] = 4'hF; wdata[2] = 32'hDEAD_BEEF;
        @(posedge clk); #3; ce[2] = 1'b0;
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #3; rst = 1'b1;
        n = 0;
        repeat (8) begin @(negedge clk); if (ack[2]) n++; end
        check("midrst_no_ack", 2, 32'(n), 32'd0);
        do_access(2, 1'b1, 1'b0, 32'h50, 4'hF, 32'h0, 1, rd, er, lat);
        check("midrst_reload", 2, rd, 32'hA5A5_0004);
        check("midrst_lat", 2, 32'(lat), 32'd4);

        // Randomised traffic, checked every cycle by the model.
        for (int it = 0; it < 300; it++) begin
            i = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
            else a = 32'h40 + 32'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: begin a[1:0] = 2'b00; s = 4'b1111; end
                1: begin a[0] = 1'b0; s = (a[1] ? 4'b0011 : 4'b1100); end
                2: begin lo = int'(a[1:0]); s = 4'b1000 >> lo; end
                default: s = 4'($urandom);
            endcase
            do_access(i, 1'b1, 1'($urandom), a, s, $urandom, int'($urandom_range(1, 2)), rd, er, lat);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
